// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: N-channel round-robin / fixed-priority arbiter onto a single memory port.
module riscv_mem_arbiter #(
  parameter int N_CH       = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_CH-1:0]                    ch_valid_i,
  output logic [N_CH-1:0]                    ch_ready_o,
  input  logic [N_CH*ADDR_WIDTH-1:0]         ch_addr_i,
  input  logic [N_CH*DATA_WIDTH-1:0]         ch_wdata_i,
  input  logic [N_CH*(DATA_WIDTH/8)-1:0]     ch_we_i,
  output logic [DATA_WIDTH-1:0]              ch_rdata_o,
  output logic                               mem_valid_o,
  input  logic                               mem_ready_i,
  output logic [ADDR_WIDTH-1:0]              mem_addr_o,
  output logic [DATA_WIDTH-1:0]              mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]            mem_we_o,
  input  logic [DATA_WIDTH-1:0]              mem_rdata_i,
  output logic [$clog2(N_CH)-1:0]            grant_o,
  output logic                               busy_o
);
  localparam int GW = $clog2(N_CH);
  localparam int BW = DATA_WIDTH / 8;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [GW-1:0] grant_q, rr_ptr, winner, cand;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BW-1:0] we_q;
  logic found;
  logic any_req;
  assign any_req = |ch_valid_i;
  // Search order starts at rr_ptr in round-robin mode, at channel 0 in fixed-priority mode.
  always_comb begin
    winner = '0;
    found = 1'b0;
    cand = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = GW'((ARB_MODE == 1) ? i : (int'(rr_ptr) + i) % N_CH);
      if (!found && ch_valid_i[cand]) begin
        found = 1'b1;
        winner = cand;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      grant_q <= '0;
      rr_ptr <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && any_req) begin
        grant_q <= winner;
        addr_q <= ch_addr_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_q <= ch_wdata_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
        we_q <= ch_we_i[int'(winner)*BW +: BW];
      end
      if (state == BUSY && mem_ready_i)
        rr_ptr <= (grant_q == GW'(N_CH - 1)) ? '0 : grant_q + 1'b1;
    end
  end
  always_comb
    state_n = (state == IDLE) ? (any_req ? BUSY : IDLE) : (mem_ready_i ? IDLE : BUSY);
  always_comb begin
    busy_o = (state == BUSY);
    mem_valid_o = busy_o;
    mem_addr_o = addr_q;
    mem_wdata_o = wdata_q;
    mem_we_o = busy_o ? we_q : '0;
    ch_ready_o = (busy_o && mem_ready_i) ? N_CH'(1) << grant_q : '0;
    ch_rdata_o = mem_rdata_i;
    grant_o = grant_q;
  end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: three arbiter configurations on shared stimulus, checked against a transaction-level model.
module tb_riscv_mem_arbiter;
  logic clk, rst_n;
  logic [3:0] valid;
  logic [127:0] addr, wdata;
  logic [15:0] we;
  logic mem_ready;
  logic [31:0] mem_rdata;
  int n_checks = 0;
  int n_fail = 0;

  logic [1:0] a_rdy;
  logic [3:0] b_rdy, c_rdy;
  logic a_g;
  logic [1:0] b_g, c_g;
  logic [3:0] o_rdy [3];
  logic [1:0] o_g [3];
  logic o_busy [3], o_mv [3];
  logic [31:0] o_addr [3], o_wd [3], o_rd [3];
  logic [3:0] o_we [3];

  riscv_mem_arbiter #(.N_CH(2), .ARB_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .ch_valid_i(valid[1:0]), .ch_ready_o(a_rdy),
    .ch_addr_i(addr[63:0]), .ch_wdata_i(wdata[63:0]), .ch_we_i(we[7:0]), .ch_rdata_o(o_rd[0]),
    .mem_valid_o(o_mv[0]), .mem_ready_i(mem_ready), .mem_addr_o(o_addr[0]), .mem_wdata_o(o_wd[0]),
    .mem_we_o(o_we[0]), .mem_rdata_i(mem_rdata), .grant_o(a_g), .busy_o(o_busy[0]));
  riscv_mem_arbiter #(.N_CH(4), .ARB_MODE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ch_valid_i(valid), .ch_ready_o(b_rdy),
    .ch_addr_i(addr), .ch_wdata_i(wdata), .ch_we_i(we), .ch_rdata_o(o_rd[1]),
    .mem_valid_o(o_mv[1]), .mem_ready_i(mem_ready), .mem_addr_o(o_addr[1]), .mem_wdata_o(o_wd[1]),
    .mem_we_o(o_we[1]), .mem_rdata_i(mem_rdata), .grant_o(b_g), .busy_o(o_busy[1]));
  riscv_mem_arbiter #(.N_CH(4), .ARB_MODE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .ch_valid_i(valid), .ch_ready_o(c_rdy),
    .ch_addr_i(addr), .ch_wdata_i(wdata), .ch_we_i(we), .ch_rdata_o(o_rd[2]),
    .mem_valid_o(o_mv[2]), .mem_ready_i(mem_ready), .mem_addr_o(o_addr[2]), .mem_wdata_o(o_wd[2]),
    .mem_we_o(o_we[2]), .mem_rdata_i(mem_rdata), .grant_o(c_g), .busy_o(o_busy[2]));

  assign o_rdy[0] = {2'b00, a_rdy};
  assign o_rdy[1] = b_rdy;
  assign o_rdy[2] = c_rdy;
  assign o_g[0] = {1'b0, a_g};
  assign o_g[1] = b_g;
  assign o_g[2] = c_g;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transaction-level reference: one outstanding request per arbiter, pointer arithmetic for fairness.
  int m_n [3] = '{2, 4, 4};
  bit m_fp [3] = '{1'b0, 1'b0, 1'b1};
  bit m_busy [3];
  int m_g [3], m_ptr [3];
  logic [31:0] m_addr [3], m_wd [3];
  logic [3:0] m_we [3];

  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      logic [3:0] v;
      int w;
      v = valid & 4'((1 << m_n[i]) - 1);
      w = -1;
      if (!rst_n) begin
        m_busy[i] = 0; m_g[i] = 0; m_ptr[i] = 0;
        m_addr[i] = '0; m_wd[i] = '0; m_we[i] = '0;
      end else if (!m_busy[i] && v != 0) begin
        for (int k = 0; k < m_n[i]; k++) begin
          int c;
          c = m_fp[i] ? k : (m_ptr[i] + k) % m_n[i];
          if (w < 0 && v[c]) w = c;
        end
        m_busy[i] = 1; m_g[i] = w;
        m_addr[i] = addr[w*32 +: 32];
        m_wd[i] = wdata[w*32 +: 32];
        m_we[i] = we[w*4 +: 4];
      end else if (m_busy[i] && mem_ready) begin
        m_busy[i] = 0;
        m_ptr[i] = (m_g[i] + 1) % m_n[i];
      end
    end
  endtask

  task automatic model_check();
    for (int i = 0; i < 3; i++) begin
      logic [3:0] er, ew;
      er = (m_busy[i] && mem_ready) ? 4'(1 << m_g[i]) : 4'h0;
      ew = m_busy[i] ? m_we[i] : 4'h0;
      n_checks++;
      if ({o_busy[i], o_mv[i], o_rdy[i], o_we[i], o_g[i], o_rd[i]} !== {m_busy[i], m_busy[i], er, ew, 2'(m_g[i]), mem_rdata}
          || (m_busy[i] && {o_addr[i], o_wd[i]} !== {m_addr[i], m_wd[i]})) begin
        n_fail++;
        $display("FAIL model_dut%0d t=%0t: got busy=%b mv=%b rdy=%b we=%h g=%0d rd=%h addr=%h wd=%h; expected busy=%b rdy=%b we=%h g=%0d rd=%h addr=%h wd=%h",
                 i, $time, o_busy[i], o_mv[i], o_rdy[i], o_we[i], o_g[i], o_rd[i], o_addr[i], o_wd[i],
                 m_busy[i], er, ew, m_g[i], mem_rdata, m_addr[i], m_wd[i]);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = '0; mem_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic txn(input logic [3:0] req, input int dly);
    valid = req; mem_ready = 1'b0;
    cyc();
    repeat (dly) cyc();
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0; valid = '0;
    cyc();
  endtask

  typedef struct {
    logic [3:0] warm;
    logic [3:0] req;
    int ga, gb, gc;
  } vec_t;
  vec_t tbl [7];

  initial begin
    tbl[0] = '{4'b0001, 4'b0011, 1, 1, 0};
    tbl[1] = '{4'b0010, 4'b0011, 0, 0, 0};
    tbl[2] = '{4'b1000, 4'b1001, 0, 0, 0};
    tbl[3] = '{4'b0100, 4'b1010, 1, 3, 1};
    tbl[4] = '{4'b0100, 4'b0011, 0, 0, 0};
    tbl[5] = '{4'b0001, 4'b1100, 0, 2, 2};
    tbl[6] = '{4'b0010, 4'b1111, 0, 2, 0};
    rst_n = 1'b0; valid = '0; addr = '0; wdata = '0; we = '0; mem_ready = 1'b0; mem_rdata = '0;
    do_reset();
    do_reset();
    settle();
    for (int i = 0; i < 3; i++) begin
      chk("reset_busy", 32'(o_busy[i]), 0);
      chk("reset_mvalid", 32'(o_mv[i]), 0);
      chk("reset_we", 32'(o_we[i]), 0);
      chk("reset_ready", 32'(o_rdy[i]), 0);
      chk("reset_grant", 32'(o_g[i]), 0);
    end
    tick();

    for (int t = 0; t < 7; t++) begin
      do_reset();
      addr = {$urandom, $urandom, $urandom, $urandom};
      txn(tbl[t].warm, 0);
      txn(tbl[t].req, 1);
      chk("tbl_grant_rr2", 32'(o_g[0]), tbl[t].ga);
      chk("tbl_grant_rr4", 32'(o_g[1]), tbl[t].gb);
      chk("tbl_grant_fp4", 32'(o_g[2]), tbl[t].gc);
    end

    // ch0 read, memory answers on the third BUSY cycle
    do_reset();
    addr[31:0] = 32'h100; we = '0; valid = 4'b0001;
    settle(); chk("rd_idle_mvalid", 32'(o_mv[0]), 0); tick();
    settle(); chk("rd_busy_addr", o_addr[0], 32'h100); tick();
    cyc();
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    settle();
    chk("rd_ready", 32'(o_rdy[0]), 1);
    chk("rd_rdata", o_rd[0], 32'hDEADBEEF);
    chk("rd_we", 32'(o_we[0]), 0);
    chk("rd_grant", 32'(o_g[0]), 0);
    tick();
    mem_ready = 1'b0; valid = '0;
    settle(); chk("rd_ready_once", 32'(o_rdy[0]), 0); tick();

    // two held requesters alternate with an IDLE gap between grants
    do_reset();
    valid = 4'b0011;
    for (int t = 0; t < 4; t++) begin
      mem_ready = 1'b0;
      settle(); chk("alt_idle_gap", 32'(o_busy[0]), 0); tick();
      mem_ready = 1'b1;
      settle();
      chk("alt_grant", 32'(o_g[0]), t % 2);
      chk("alt_ready", 32'(o_rdy[0]), 1 << (t % 2));
      tick();
    end
    valid = '0; mem_ready = 1'b0;
    cyc();

    // fixed priority: 1, 1 again on re-request, then 3
    do_reset();
    valid = 4'b1010;
    for (int t = 0; t < 3; t++) begin
      if (t == 2) valid = 4'b1000;
      mem_ready = 1'b0; cyc();
      mem_ready = 1'b1;
      settle(); chk("fp_grant", 32'(o_g[2]), t == 2 ? 3 : 1); tick();
    end
    valid = '0; mem_ready = 1'b0;
    cyc();

    // round-robin wrap from pointer 3 to 0
    do_reset();
    txn(4'b0100, 0);
    valid = 4'b1001;
    for (int t = 0; t < 2; t++) begin
      mem_ready = 1'b0; cyc();
      mem_ready = 1'b1;
      settle(); chk("wrap_grant", 32'(o_g[1]), t == 0 ? 3 : 0); tick();
    end
    valid = '0; mem_ready = 1'b0;
    cyc();

    // write whose requester changes address mid-transaction
    do_reset();
    addr[63:32] = 32'h200; wdata[63:32] = 32'hCAFE0000; we[7:4] = 4'b1100; valid = 4'b0010;
    cyc();
    addr[63:32] = 32'h300;
    settle();
    chk("wr_addr_hold", o_addr[0], 32'h200);
    chk("wr_we", 32'(o_we[0]), 32'hC);
    chk("wr_wdata", o_wd[0], 32'hCAFE0000);
    tick();
    cyc();
    mem_ready = 1'b1;
    settle();
    chk("wr_addr_done", o_addr[0], 32'h200);
    chk("wr_we_done", 32'(o_we[0]), 32'hC);
    chk("wr_ready", 32'(o_rdy[0]), 2);
    tick();
    valid = '0; mem_ready = 1'b0;
    cyc();

    // reset aborts an in-flight transaction; ready in IDLE is ignored
    do_reset();
    valid = 4'b0001;
    cyc();
    settle(); chk("abort_busy_before", 32'(o_busy[0]), 1); tick();
    do_reset();
    mem_ready = 1'b1;
    settle();
    chk("abort_busy", 32'(o_busy[0]), 0);
    chk("abort_mvalid", 32'(o_mv[0]), 0);
    chk("abort_ready", 32'(o_rdy[0]), 0);
    tick();
    mem_ready = 1'b0;
    valid = 4'b0001;
    cyc();
    mem_ready = 1'b1;
    settle(); chk("abort_recover", 32'(o_rdy[0]), 1); tick();
    valid = '0; mem_ready = 1'b0;
    cyc();

    for (int t = 0; t < 500; t++) begin
      valid = 4'($urandom);
      addr = {$urandom, $urandom, $urandom, $urandom};
      wdata = {$urandom, $urandom, $urandom, $urandom};
      we = 16'($urandom);
      mem_ready = ($urandom % 3) != 0;
      mem_rdata = $urandom;
      rst_n = ($urandom % 40) != 0;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
